// File: rtl/i2c_pkg.sv
// Shared constants and FSM state encoding for the I2C command arbiter.
package i2c_pkg;

  localparam int REQ_DATA_W = 16;
  localparam int FRAME_W    = 24;
  localparam logic [7:0] DEV_BYTE = 8'h34;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_GAP    = 3'd4,
    S_REPORT = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: the search begins one past the last grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_valid
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = last_grant;
    found     = 1'b0;
    cand      = '0;
    any_valid = |req;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Arbitrates register-write requests onto one I2C frame engine, with
// NACK/timeout retry, a fixed inter-attempt gap and per-requester completion.
module i2c_cmd_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int MAX_RETRY  = 3,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*REQ_DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [NUM_REQ-1:0]           o_req_done,
  output logic [NUM_REQ-1:0]           o_req_err,
  output logic                         o_i2c_start,
  output logic [FRAME_W-1:0]           o_i2c_frame,
  input  logic                         i_i2c_done,
  input  logic                         i_i2c_nack,
  output logic                         o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t                  state;
  logic [IDX_W-1:0]        winner;
  logic [IDX_W-1:0]        last_grant;
  logic [FRAME_W-1:0]      frame;
  logic [RTY_W-1:0]        rty_cnt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    err_flag;

  logic [IDX_W-1:0]        rr_grant;
  logic                    rr_any;
  logic [REQ_DATA_W-1:0]   sel_data;
  logic [NUM_REQ-1:0]      win_oh;
  logic                    frame_fail;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .any_valid  (rr_any)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rr_grant == IDX_W'(k)) sel_data = i_req_data[k*REQ_DATA_W +: REQ_DATA_W];
    end
  end

  always_comb begin
    win_oh         = '0;
    win_oh[winner] = 1'b1;
  end

  // Failure is decided in the TIMEOUT-th consecutive WAIT cycle without a done.
  assign frame_fail = (i_i2c_done && i_i2c_nack) || (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      winner     <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      frame      <= '0;
      rty_cnt    <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      err_flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rr_any) begin
            state    <= S_GRANT;
            winner   <= rr_grant;
            frame    <= {DEV_BYTE, sel_data};
            rty_cnt  <= '0;
            err_flag <= 1'b0;
          end
        end
        S_GRANT: state <= S_ISSUE;
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (i_i2c_done && !i_i2c_nack) begin
            err_flag <= 1'b0;
            state    <= S_REPORT;
          end else if (frame_fail) begin
            if (rty_cnt == RTY_MAX) begin
              err_flag <= 1'b1;
              state    <= S_REPORT;
            end else begin
              rty_cnt <= rty_cnt + 1'b1;
              gap_cnt <= '0;
              state   <= S_GAP;
            end
          end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_ISSUE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        S_REPORT: begin
          last_grant <= winner;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign o_req_ready = (state == S_GRANT) ? win_oh : '0;
  assign o_req_done  = (state == S_REPORT) ? win_oh : '0;
  assign o_req_err   = (state == S_REPORT && err_flag) ? win_oh : '0;
  assign o_i2c_start = (state == S_ISSUE);
  assign o_i2c_frame = frame;
  assign o_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a completion scoreboard.
module tb_i2c_cmd_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int MAX_RETRY  = 3;
  localparam int GAP_CYCLES = 4;
  localparam int TIMEOUT    = 20;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req_valid;
  logic [31:0] i_req_data;
  logic [1:0]  o_req_ready;
  logic [1:0]  o_req_done;
  logic [1:0]  o_req_err;
  logic        o_i2c_start;
  logic [23:0] o_i2c_frame;
  logic        i_i2c_done;
  logic        i_i2c_nack;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit ready_seen;

  typedef struct {
    int          idx;
    logic        err;
    logic [23:0] frame;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  i2c_cmd_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .MAX_RETRY  (MAX_RETRY),
    .GAP_CYCLES (GAP_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .o_req_done  (o_req_done),
    .o_req_err   (o_req_err),
    .o_i2c_start (o_i2c_start),
    .o_i2c_frame (o_i2c_frame),
    .i_i2c_done  (i_i2c_done),
    .i_i2c_nack  (i_i2c_nack),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [1:0] oh(input int i);
    logic [1:0] one;
    one = 2'b01;
    oh  = one << i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic push(input int idx, input logic err, input logic [23:0] frame);
    exp_t e;
    e.idx = idx; e.err = err; e.frame = frame;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string tag, input int idx);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!o_req_ready[idx] && n < 50);
    check(tag, {30'd0, o_req_ready}, {30'd0, oh(idx)});
  endtask

  task automatic wait_start(input string tag, output int c);
    int n;
    n = 0;
    while (!o_i2c_start && n < 200) begin
      step();
      n++;
      if (|o_req_ready) ready_seen = 1'b1;
    end
    check(tag, {31'd0, o_i2c_start}, 32'd1);
    c = cyc;
  endtask

  task automatic respond(input logic nack, output int d);
    step();
    i_i2c_done = 1'b1;
    i_i2c_nack = nack;
    d = cyc;
    step();
    i_i2c_done = 1'b0;
    i_i2c_nack = 1'b0;
  endtask

  // Completions are matched in order against what the stimulus queued.
  always @(negedge i_clk) begin
    if (!i_rst && |o_req_done) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", {30'd0, o_req_done}, 32'd0);
      end else begin
        got = sb.pop_front();
        check("sb_done_idx", {30'd0, o_req_done}, {30'd0, oh(got.idx)});
        check("sb_err", {30'd0, o_req_err}, got.err ? {30'd0, oh(got.idx)} : 32'd0);
        check("sb_frame", {8'd0, o_i2c_frame}, {8'd0, got.frame});
      end
    end
  end

  initial begin
    int s, d, prev, n, extra;
    i_rst = 1'b1; i_req_valid = '0; i_req_data = '0;
    i_i2c_done = 1'b0; i_i2c_nack = 1'b0;
    step(); step();
    check("rst_ready", {30'd0, o_req_ready}, 32'd0);
    check("rst_done",  {30'd0, o_req_done}, 32'd0);
    check("rst_err",   {30'd0, o_req_err}, 32'd0);
    check("rst_start", {31'd0, o_i2c_start}, 32'd0);
    check("rst_frame", {8'd0, o_i2c_frame}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    i_rst = 1'b0;
    step();
    check("idle_busy", {31'd0, o_busy}, 32'd0);

    // Both requesters at once: req0 first, req1 next, re-raised req0 waits.
    push(0, 1'b0, 24'h341234);
    push(1, 1'b0, 24'h345678);
    i_req_data = {16'h5678, 16'h1234};
    i_req_valid = 2'b11;
    wait_ready("t2_ready0", 0);
    check("t2_busy", {31'd0, o_busy}, 32'd1);
    i_req_valid = 2'b10;
    wait_start("t2_start0", s);
    check("t2_frame0", {8'd0, o_i2c_frame}, 32'h00341234);
    respond(1'b0, d);
    check("t2_done0", {30'd0, o_req_done}, 32'd1);
    wait_ready("t2_ready1", 1);
    i_req_valid = 2'b01;
    i_req_data[15:0] = 16'h0ABC;
    push(0, 1'b0, 24'h340ABC);
    ready_seen = 1'b0;
    wait_start("t2_start1", s);
    check("t2_frame1", {8'd0, o_i2c_frame}, 32'h00345678);
    respond(1'b0, d);
    check("t2_done1", {30'd0, o_req_done}, 32'd2);
    check("t2_no_early_ready", {31'd0, ready_seen}, 32'd0);
    step();
    check("t2_idle_no_ready", {30'd0, o_req_ready}, 32'd0);
    step();
    check("t2_ready0_again", {30'd0, o_req_ready}, 32'd1);
    i_req_valid = 2'b00;
    wait_start("t2_start2", s);
    check("t2_frame2", {8'd0, o_i2c_frame}, 32'h00340ABC);
    respond(1'b0, d);
    check("t2_done2", {30'd0, o_req_done}, 32'd1);

    // Single request, exact latency, data changes after acceptance ignored.
    step(); step();
    push(0, 1'b0, 24'h341E00);
    i_req_data[15:0] = 16'h1E00;
    i_req_valid = 2'b01;
    step();
    check("t1_ready", {30'd0, o_req_ready}, 32'd1);
    i_req_valid = 2'b00;
    i_req_data[15:0] = 16'hDEAD;
    step();
    check("t1_start", {31'd0, o_i2c_start}, 32'd1);
    check("t1_frame", {8'd0, o_i2c_frame}, 32'h00341E00);
    respond(1'b0, d);
    check("t1_done", {30'd0, o_req_done}, 32'd1);
    check("t1_err",  {30'd0, o_req_err}, 32'd0);
    step();
    check("t1_done_pulse", {30'd0, o_req_done}, 32'd0);

    // NACK, NACK, ACK on requester 1.
    push(1, 1'b0, 24'h347F01);
    i_req_data[31:16] = 16'h7F01;
    i_req_valid = 2'b10;
    wait_ready("t3_ready", 1);
    i_req_valid = 2'b00;
    n = 0;
    for (int a = 0; a < 3; a++) begin
      wait_start("t3_start", s);
      n++;
      if (a > 0) check("t3_gap", s - d, GAP_CYCLES + 1);
      respond((a < 2) ? 1'b1 : 1'b0, d);
    end
    check("t3_done", {30'd0, o_req_done}, 32'd2);
    check("t3_err",  {30'd0, o_req_err}, 32'd0);
    check("t3_starts", n, 3);

    // Four NACKs exhaust the retries.
    push(0, 1'b1, 24'h340001);
    i_req_data[15:0] = 16'h0001;
    i_req_valid = 2'b01;
    wait_ready("t4_ready", 0);
    i_req_valid = 2'b00;
    n = 0;
    for (int a = 0; a < 4; a++) begin
      wait_start("t4_start", s);
      n++;
      if (a > 0) check("t4_gap", s - d, GAP_CYCLES + 1);
      respond(1'b1, d);
      if (a < 3) check("t4_no_done", {30'd0, o_req_done}, 32'd0);
    end
    check("t4_done", {30'd0, o_req_done}, 32'd1);
    check("t4_err",  {30'd0, o_req_err}, 32'd1);
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (o_i2c_start) extra++;
    end
    check("t4_starts", n + extra, 4);

    // Engine silent: every attempt times out.
    push(1, 1'b1, 24'h34FFFF);
    i_req_data[31:16] = 16'hFFFF;
    i_req_valid = 2'b10;
    wait_ready("t5_ready", 1);
    i_req_valid = 2'b00;
    prev = 0;
    for (int a = 0; a < 4; a++) begin
      wait_start("t5_start", s);
      if (a > 0)
        check("t5_interval", {31'd0, (s - prev > TIMEOUT + GAP_CYCLES - 1) &&
                                     (s - prev <= TIMEOUT + GAP_CYCLES + 2)}, 32'd1);
      prev = s;
      step();
    end
    n = 0;
    while (!(|o_req_done) && n < 60) begin
      step();
      n++;
    end
    check("t5_done", {30'd0, o_req_done}, 32'd2);
    check("t5_err",  {30'd0, o_req_err}, 32'd2);
    step();

    // Reset during WAIT drops the request silently.
    i_req_data[15:0] = 16'h2222;
    i_req_valid = 2'b01;
    wait_ready("t6_ready", 0);
    i_req_valid = 2'b00;
    wait_start("t6_start", s);
    step();
    #1 i_rst = 1'b1;
    #1;
    check("t6_rst_ready", {30'd0, o_req_ready}, 32'd0);
    check("t6_rst_done",  {30'd0, o_req_done}, 32'd0);
    check("t6_rst_start", {31'd0, o_i2c_start}, 32'd0);
    check("t6_rst_frame", {8'd0, o_i2c_frame}, 32'd0);
    check("t6_rst_busy",  {31'd0, o_busy}, 32'd0);
    step();
    i_rst = 1'b0;
    i_i2c_done = 1'b1;
    step();
    i_i2c_done = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (|o_req_done || o_busy) n++;
    end
    check("t6_silent", n, 0);
    push(1, 1'b0, 24'h344321);
    i_req_data[31:16] = 16'h4321;
    i_req_valid = 2'b10;
    wait_ready("t7_ready", 1);
    i_req_valid = 2'b00;
    wait_start("t7_start", s);
    check("t7_frame", {8'd0, o_i2c_frame}, 32'h00344321);
    respond(1'b0, d);
    check("t7_done", {30'd0, o_req_done}, 32'd2);
    check("t7_err",  {30'd0, o_req_err}, 32'd0);
    step(); step();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
